// File: rtl/tx_pshape_lut_fir_if.sv
// Port bundle for the 4-ASK pulse-shaping filter: symbol handshake, coefficient
// write port, flag clear, filtered output and sticky status flags.
interface tx_pshape_lut_fir_if #(
   parameter int CW = 18,
   parameter int OW = 18,
   parameter int AW = 4
);
   // Symbol handshake: a symbol is taken on a rising clk edge where
   // sym_valid && sym_ready; sym_ready is high only on a sample strobe at
   // phase 0, and the producer must hold sym_data stable while sym_valid waits.
   logic                 samp_en;
   logic                 sym_valid;
   logic [1:0]           sym_data;
   logic                 sym_ready;
   logic                 coef_we;
   logic [AW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 flags_clr;
   logic signed [OW-1:0] y;
   logic                 y_valid;
   logic                 underflow;
   logic                 sat;

   modport master (
      output samp_en, sym_valid, sym_data, coef_we, coef_addr, coef_data, flags_clr,
      input  sym_ready, y, y_valid, underflow, sat
   );

   modport slave (
      input  samp_en, sym_valid, sym_data, coef_we, coef_addr, coef_data, flags_clr,
      output sym_ready, y, y_valid, underflow, sat
   );
endinterface

// File: rtl/tx_pshape_lut_fir.sv
// Multiplier-free 4-ASK transmit pulse-shaping filter: zero-insertion upsampler
// feeding a folded, symmetric, runtime-loadable FIR with a 3-stage pipeline.
module tx_pshape_lut_fir #(
   parameter int NTAPS  = 21,
   parameter int SPS    = 4,
   parameter int CW     = 18,
   parameter int OW     = 18,
   parameter int OSHIFT = 2
) (
   input logic               clk,
   input logic               reset,
   tx_pshape_lut_fir_if.slave bus
);
   localparam int NHALF = (NTAPS + 1) / 2;
   localparam int PW    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int PWID  = CW + 4;
   localparam int AWID  = PWID + $clog2(NHALF);
   localparam logic signed [AWID-1:0] YMAX = AWID'((64'sd1 <<< (OW - 1)) - 64'sd1);
   localparam logic signed [AWID-1:0] YMIN = AWID'(-(64'sd1 <<< (OW - 1)));

   logic [PW-1:0]          phase;
   logic                   slot;
   logic signed [2:0]      sym_amp;
   logic signed [2:0]      line [NTAPS];
   logic signed [CW-1:0]   h    [NHALF];
   logic signed [3:0]      k    [NHALF];
   logic signed [PWID-1:0] prod [NHALF];
   logic signed [AWID-1:0] sum, acc, acc_sh;
   logic                   sh_v, p_v, acc_v;
   logic                   clip_hi, clip_lo;
   logic signed [OW-1:0]   y_next, y_q;
   logic                   y_valid_q, underflow_q, sat_q;

   assign slot          = (phase == '0);
   assign bus.sym_ready = bus.samp_en && slot;

   always_comb begin
      case (bus.sym_data)
         2'b00:   sym_amp = 3'sb101;
         2'b01:   sym_amp = 3'sb111;
         2'b10:   sym_amp = 3'sb001;
         default: sym_amp = 3'sb011;
      endcase
   end

   // Zero insertion: only a phase-0 strobe with a waiting symbol loads a non-zero amplitude.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
         sh_v  <= 1'b0;
         for (int i = 0; i < NTAPS; i++) line[i] <= '0;
      end else begin
         sh_v <= bus.samp_en;
         if (bus.samp_en) begin
            phase   <= (phase == PW'(SPS - 1)) ? '0 : phase + PW'(1);
            line[0] <= (slot && bus.sym_valid) ? sym_amp : 3'sb000;
            for (int i = 1; i < NTAPS; i++) line[i] <= line[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < NHALF; j++) h[j] <= '0;
      end else if (bus.coef_we && (int'(bus.coef_addr) < NHALF)) begin
         h[bus.coef_addr] <= bus.coef_data;
      end
   end

   always_comb begin
      for (int j = 0; j < NHALF; j++)
         k[j] = 4'(line[j]) + ((j < NHALF - 1) ? 4'(line[NTAPS-1-j]) : 4'sb0000);
   end

   // |k| <= 6 needs at most three shifted copies of the coefficient.
   function automatic logic signed [PWID-1:0] shmul(input logic signed [CW-1:0] c,
                                                    input logic signed [3:0]    kk);
      logic signed [PWID-1:0] ce;
      logic signed [PWID-1:0] mag;
      logic [2:0]             m;
      ce  = PWID'(c);
      m   = kk[3] ? 3'(-kk) : 3'(kk);
      mag = '0;
      if (m[0]) mag = mag + ce;
      if (m[1]) mag = mag + (ce <<< 1);
      if (m[2]) mag = mag + (ce <<< 2);
      return kk[3] ? -mag : mag;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_v <= 1'b0;
         for (int j = 0; j < NHALF; j++) prod[j] <= '0;
      end else begin
         p_v <= sh_v;
         for (int j = 0; j < NHALF; j++) prod[j] <= shmul(h[j], k[j]);
      end
   end

   always_comb begin
      sum = '0;
      for (int j = 0; j < NHALF; j++) sum = sum + AWID'(prod[j]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc   <= '0;
         acc_v <= 1'b0;
      end else begin
         acc   <= sum;
         acc_v <= p_v;
      end
   end

   assign acc_sh  = acc >>> OSHIFT;
   assign clip_hi = (acc_sh > YMAX);
   assign clip_lo = (acc_sh < YMIN);
   assign y_next  = clip_hi ? OW'(YMAX) : (clip_lo ? OW'(YMIN) : OW'(acc_sh));

   // Set events take priority over flags_clr so a clip in the same cycle is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_q         <= '0;
         y_valid_q   <= 1'b0;
         underflow_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         y_valid_q <= acc_v;
         if (acc_v) y_q <= y_next;
         if (acc_v && (clip_hi || clip_lo)) sat_q <= 1'b1;
         else if (bus.flags_clr)            sat_q <= 1'b0;
         if (bus.samp_en && slot && !bus.sym_valid) underflow_q <= 1'b1;
         else if (bus.flags_clr)                    underflow_q <= 1'b0;
      end
   end

   assign bus.y         = y_q;
   assign bus.y_valid   = y_valid_q;
   assign bus.underflow = underflow_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_tx_pshape_lut_fir.sv
// Bench for tx_pshape_lut_fir: directed scenarios plus random streams against a
// convolution model of the upsampled symbol stream with the full symmetric response.
module tb_tx_pshape_lut_fir;
   localparam int NTAPS  = 21;
   localparam int NHALF  = 11;
   localparam int CW     = 18;
   localparam int OW     = 18;
   localparam int AW     = 4;
   localparam int OSHIFT = 2;
   localparam int LAT    = 3;
   localparam longint YMAX = (64'sd1 <<< (OW - 1)) - 1;
   localparam longint YMIN = -(64'sd1 <<< (OW - 1));

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bit                   sel;
   logic                 samp_en, sym_valid, coef_we, flags_clr;
   logic [1:0]           sym_data;
   logic [AW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;

   tx_pshape_lut_fir_if #(.CW(CW), .OW(OW), .AW(AW)) bus4 ();
   tx_pshape_lut_fir_if #(.CW(CW), .OW(OW), .AW(AW)) bus1 ();

   tx_pshape_lut_fir #(.NTAPS(NTAPS), .SPS(4), .CW(CW), .OW(OW), .OSHIFT(OSHIFT)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave));
   tx_pshape_lut_fir #(.NTAPS(NTAPS), .SPS(1), .CW(CW), .OW(OW), .OSHIFT(OSHIFT)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   assign bus4.samp_en   = samp_en & ~sel;
   assign bus1.samp_en   = samp_en & sel;
   assign bus4.coef_we   = coef_we & ~sel;
   assign bus1.coef_we   = coef_we & sel;
   assign bus4.sym_valid = sym_valid;
   assign bus1.sym_valid = sym_valid;
   assign bus4.sym_data  = sym_data;
   assign bus1.sym_data  = sym_data;
   assign bus4.coef_addr = coef_addr;
   assign bus1.coef_addr = coef_addr;
   assign bus4.coef_data = coef_data;
   assign bus1.coef_data = coef_data;
   assign bus4.flags_clr = flags_clr;
   assign bus1.flags_clr = flags_clr;

   logic signed [OW-1:0] y_o;
   logic                 yv_o, und_o, sat_o, rdy_o;
   assign y_o   = sel ? bus1.y         : bus4.y;
   assign yv_o  = sel ? bus1.y_valid   : bus4.y_valid;
   assign und_o = sel ? bus1.underflow : bus4.underflow;
   assign sat_o = sel ? bus1.sat       : bus4.sat;
   assign rdy_o = sel ? bus1.sym_ready : bus4.sym_ready;

   int total = 0;
   int bad   = 0;

   // Reference state: upsampled input history, coefficient table, expected outputs.
   int                   sps_m, phase_m, cyc;
   int                   hist [NTAPS];
   int                   hm   [NHALF];
   bit                   pend;
   logic signed [OW-1:0] exp_q [$];
   bit                   clip_q[$];
   int                   due_q [$];
   longint               y_m;
   bit                   yv_m, sat_m, und_m;

   int     nz_cnt, first_nz, last_nz, acc_cyc, hs_cnt;
   longint first_nz_val, last_nz_val;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int amp(input logic [1:0] c);
      return 2 * int'(c) - 3;
   endfunction

   function automatic longint conv_now();
      longint s;
      s = 0;
      for (int t = 0; t < NTAPS; t++)
         s += longint'(hm[(t < NHALF) ? t : NTAPS - 1 - t]) * hist[t];
      return s >>> OSHIFT;
   endfunction

   task automatic model_reset();
      sps_m   = sel ? 1 : 4;
      phase_m = 0;
      pend    = 0;
      for (int t = 0; t < NTAPS; t++) hist[t] = 0;
      for (int j = 0; j < NHALF; j++) hm[j] = 0;
      exp_q.delete(); clip_q.delete(); due_q.delete();
      y_m = 0; yv_m = 0; sat_m = 0; und_m = 0;
   endtask

   task automatic clr_marks();
      nz_cnt = 0; first_nz = 0; last_nz = 0; hs_cnt = 0;
      first_nz_val = 0; last_nz_val = 0;
   endtask

   task automatic idle_inputs();
      samp_en = 0; sym_valid = 0; sym_data = 0; coef_we = 0;
      coef_addr = 0; coef_data = 0; flags_clr = 0;
   endtask

   // One clock: check ready before the edge, advance the model at the edge, check outputs after.
   task automatic step();
      bit     exp_ready;
      longint v, vs;
      @(negedge clk);
      exp_ready = samp_en && (phase_m == 0);
      chk("sym_ready", rdy_o, exp_ready);
      if (rdy_o && sym_valid) hs_cnt++;
      @(posedge clk);
      cyc++;
      if (flags_clr) begin sat_m = 0; und_m = 0; end
      yv_m = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         yv_m = 1;
         y_m  = exp_q.pop_front();
         if (clip_q.pop_front()) sat_m = 1;
         void'(due_q.pop_front());
      end
      if (pend) begin
         v  = conv_now();
         vs = (v > YMAX) ? YMAX : ((v < YMIN) ? YMIN : v);
         exp_q.push_back(OW'(vs));
         clip_q.push_back(vs != v);
         due_q.push_back(cyc + LAT - 1);
      end
      if (coef_we && int'(coef_addr) < NHALF) hm[coef_addr] = coef_data;
      pend = samp_en;
      if (samp_en) begin
         for (int t = NTAPS - 1; t > 0; t--) hist[t] = hist[t-1];
         hist[0] = (phase_m == 0 && sym_valid) ? amp(sym_data) : 0;
         if (phase_m == 0 && !sym_valid) und_m = 1;
         if (phase_m == 0 && sym_valid) acc_cyc = cyc;
         phase_m = (phase_m + 1) % sps_m;
      end
      #1;
      chk("y_valid", yv_o, yv_m);
      chk("y", y_o, y_m);
      chk("underflow", und_o, und_m);
      chk("sat", sat_o, sat_m);
      if (yv_o && y_o != 0) begin
         if (nz_cnt == 0) begin first_nz = cyc; first_nz_val = y_o; end
         nz_cnt++;
         last_nz = cyc;
         last_nz_val = y_o;
      end
   endtask

   task automatic apply_reset(input bit which);
      idle_inputs();
      sel   = which;
      reset = 0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1;
      model_reset();
   endtask

   task automatic wcoef(input int a, input int v);
      coef_we = 1; coef_addr = AW'(a); coef_data = CW'(v);
      step();
      coef_we = 0;
   endtask

   task automatic random_run(input int n, input bit allow_we);
      for (int i = 0; i < n; i++) begin
         samp_en   = ($urandom_range(0, 3) != 0);
         sym_valid = ($urandom_range(0, 4) != 0);
         sym_data  = 2'($urandom);
         coef_we   = allow_we && ($urandom_range(0, 9) == 0);
         coef_addr = AW'($urandom);
         coef_data = CW'($urandom);
         flags_clr = ($urandom_range(0, 19) == 0);
         step();
      end
      idle_inputs();
   endtask

   initial begin
      cyc = 0;
      sel = 0;
      idle_inputs();
      clr_marks();
      acc_cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", y_o, 0);
      chk("rst_y_valid", yv_o, 0);
      chk("rst_underflow", und_o, 0);
      chk("rst_sat", sat_o, 0);
      reset = 1;
      model_reset();

      // Centre-tap impulse: one +3 symbol, then starve the input.
      wcoef(10, 32768);
      clr_marks();
      samp_en = 1; sym_valid = 1; sym_data = 2'b11;
      step();
      sym_valid = 0;
      repeat (40) step();
      chk("imp_count", nz_cnt, 1);
      chk("imp_value", last_nz_val, 24576);
      chk("imp_delay", last_nz - acc_cyc, 13);
      chk("imp_underflow", und_o, 1);

      // Outer-tap symmetry: the same tap value hits twice, 20 samples apart.
      apply_reset(0);
      wcoef(0, 1000);
      clr_marks();
      samp_en = 1; sym_valid = 1; sym_data = 2'b00;
      step();
      sym_valid = 0;
      repeat (40) step();
      chk("sym_count", nz_cnt, 2);
      chk("sym_first_delay", first_nz - acc_cyc, 3);
      chk("sym_first_value", first_nz_val, -750);
      chk("sym_last_delay", last_nz - acc_cyc, 23);
      chk("sym_last_value", last_nz_val, -750);

      // Handshake with samp_en every other cycle and sym_valid held high.
      apply_reset(0);
      for (int j = 0; j < NHALF; j++) wcoef(j, int'($urandom_range(0, 4000)));
      clr_marks();
      sym_valid = 1;
      for (int i = 0; i < 64; i++) begin
         samp_en  = ((i % 2) == 0);
         sym_data = 2'($urandom);
         step();
      end
      idle_inputs();
      chk("hs_count", hs_cnt, 8);
      chk("hs_underflow", und_o, 0);

      // Coefficient hot-write during a steady impulse train.
      apply_reset(0);
      wcoef(10, 32768);
      clr_marks();
      samp_en = 1; sym_valid = 1; sym_data = 2'b11;
      repeat (40) step();
      chk("hot_before", last_nz_val, 24576);
      coef_we = 1; coef_addr = 4'd10; coef_data = 18'sd16384;
      step();
      coef_we = 0;
      repeat (40) step();
      chk("hot_after", last_nz_val, 12288);
      idle_inputs();

      // Saturation at SPS=1, flag clear and re-assert, negative clip.
      apply_reset(1);
      for (int j = 0; j < NHALF; j++) wcoef(j, 131071);
      samp_en = 1; sym_valid = 1; sym_data = 2'b11;
      repeat (30) step();
      chk("sat_y_pos", y_o, 131071);
      chk("sat_flag", sat_o, 1);
      samp_en = 0;
      repeat (5) step();
      flags_clr = 1;
      step();
      flags_clr = 0;
      chk("sat_cleared", sat_o, 0);
      samp_en = 1;
      step();
      samp_en = 0;
      repeat (3) step();
      chk("sat_again", sat_o, 1);
      samp_en = 1; sym_data = 2'b00;
      repeat (30) step();
      chk("sat_y_neg", y_o, -131072);
      idle_inputs();

      // Random streams on both upsampling factors.
      for (int s = 0; s < 2; s++) begin
         apply_reset(s[0]);
         random_run(400, 1'b1);
         repeat (4) step();
      end

      // Asynchronous reset in the middle of output activity.
      apply_reset(0);
      random_run(60, 1'b1);
      for (int j = 0; j < NHALF; j++) wcoef(j, int'($urandom_range(1000, 20000)));
      samp_en = 1; sym_valid = 1; sym_data = 2'b11;
      repeat (8) step();
      #2 reset = 0;
      #1;
      chk("midrst_y", y_o, 0);
      chk("midrst_y_valid", yv_o, 0);
      chk("midrst_underflow", und_o, 0);
      chk("midrst_sat", sat_o, 0);
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1;
      model_reset();
      clr_marks();
      random_run(60, 1'b0);
      repeat (4) step();
      chk("post_rst_nonzero", nz_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tx_pshape_lut_fir.md
# tx_pshape_lut_fir

Parametrised multiplier-free transmit pulse-shaping filter for 4-ASK: accepts 2-bit symbol codes over a valid/ready handshake and upsamples by SPS with zero insertion. Filters through an odd-length, symmetric, runtime-loadable FIR using folded taps and shift-add products. Sits between the symbol mapper and the DAC/channel model, replacing the fixed 21-tap, hard-coded-table TX filter with a generic block.

## Interface
- NTAPS, 21, odd tap count ≥ 3; NHALF = (NTAPS+1)/2 unique coefficients
- SPS, 4, samples per symbol (≥ 1)
- CW, 18, coefficient width, signed 1s17
- OW, 18, output width, signed
- OSHIFT, 2, arithmetic right shift applied to accumulator before saturation
- clk  in  1  sample-domain clock
- reset  in  1  asynchronous, active-low; clears all state
- samp_en  in  1  sample strobe; filter advances one sample per cycle it is high
- sym_valid  in  1  symbol available
- sym_data  in  2  symbol code: 00→−3, 01→−1, 10→+1, 11→+3
- sym_ready  out  1  combinational: samp_en && phase==0
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NHALF)  coefficient index j (taps j and NTAPS−1−j; j=NHALF−1 is centre)
- coef_data  in  CW  signed coefficient value
- flags_clr  in  1  synchronous clear of sticky flags
- y  out  OW  filtered sample
- y_valid  out  1  one-cycle pulse per output sample
- underflow  out  1  sticky: symbol slot missed
- sat  out  1  sticky: output saturated

## Operation
- Phase counter 0..SPS−1, advances on each samp_en, wraps SPS−1→0. At phase 0 with samp_en: if sym_valid, symbol value enters delay line (handshake completes); else value 0 enters and underflow sets. At phases ≠0, value 0 enters. SPS=1: every sample is a symbol slot.
- Delay line: NTAPS entries of 3-bit signed amplitude {−3,−1,0,+1,+3}; shifts only on samp_en.
- Folding: for j<NHALF−1, k_j = s[j] + s[NTAPS−1−j] ∈ [−6,+6]; centre k = s[NHALF−1] ∈ [−3,+3].
- Products p_j = h_j × k_j via shifts/adds only (no multiplier inference); full precision, CW+4 bits.
- Accumulator: sum of NHALF products, width CW+4+clog2(NHALF), no internal overflow.
- Output: acc >>> OSHIFT (arithmetic), saturated to [−2^(OW−1), 2^(OW−1)−1]; any clip sets sat.
- Coefficients: NHALF registers, reset to 0. Write when coef_we: h[coef_addr] ← coef_data; coef_addr ≥ NHALF ignored. Writes during operation allowed; they affect products registered on the following edge.
- flags_clr clears underflow and sat; a same-cycle set event wins over clear.
- Reset (any time, asynchronous): delay line, coefficients, phase, pipeline, y=0, y_valid=0, underflow=0, sat=0.

## Timing
- Pipeline: edge E0 samples samp_en=1, shifts delay line; E1 registers folded products; E2 registers accumulator; E3 registers y and pulses y_valid. Latency 3 clocks; throughput one sample per clock (samp_en may stay high).
- y holds its value between y_valid pulses.
- Impulse group delay: symbol at input reaches centre tap after NHALF−1 further samp_en shifts.
- Reset release: first accepted symbol may occur on first edge with samp_en=1 (phase=0).

## Test plan
- Impulse, defaults, samp_en continuous: load h[10]=32768, others 0; send code 11 once then sym_valid=1 with code 10? no—send code 11 then stall sym_valid low → y=24576 exactly once, 13 clocks after acceptance; all other y=0; underflow=1.
- Symmetry: load only h[0]=1000; one symbol code 00 → y=−750 at 3 clocks and again at 23 clocks after acceptance; otherwise 0.
- Upsampling/handshake: SPS=4, sym_valid held high, samp_en every other cycle → sym_ready pulses every 8 clocks; exactly one symbol consumed per 4 samp_en; underflow stays 0.
- Saturation: SPS=1, all h=131071, continuous code 11 → after fill y=131071, sat=1; flags_clr → sat re-asserts next sample; code 00 stream → y=−131072.
- Reset mid-stream: assert reset between clock edges during output → y, y_valid, flags 0 immediately; after release with no coefficient reload, outputs all 0.
- Coefficient hot-write: during steady impulse-train, change h[10] 32768→16384 → outputs from the next product stage use 12288 per +3 symbol.
